mem_burst_reader: RTL and testbench

Read initiator for the main_memory port. Accepts a command (start address, word count) and splits it into the largest legal bursts (16/8/4/1 words). It issues those bursts on the memory's address/access_size/read_not_write/enable/busy interface and buffers the returned words in a FIFO. Words are delivered to a consumer over a valid/ready stream; it sits between main_memory and the instruction/data fetch logic.

---
 rtl/mem_if_pkg.sv | 36 +++
 rtl/mem_burst_reader_word_fifo.sv | 55 +++++
 rtl/mem_burst_reader.sv | 150 +++++++++++++++
 tb/tb_mem_burst_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the main_memory read initiator.
//   - access_size encodings for the memory request interface
//   - burst_len(): access_size -> burst length in words
//   - pick_size(): words remaining -> largest legal access_size
//   - state_t: burst reader FSM states
package mem_if_pkg;

    localparam logic [1:0] AS_1W  = 2'b00;
    localparam logic [1:0] AS_4W  = 2'b01;
    localparam logic [1:0] AS_8W  = 2'b10;
    localparam logic [1:0] AS_16W = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RECV   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic [4:0] burst_len(input logic [1:0] size);
        case (size)
            AS_16W:  return 5'd16;
            AS_8W:   return 5'd8;
            AS_4W:   return 5'd4;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [1:0] pick_size(input logic [31:0] remaining);
        if (remaining >= 32'd16)     return AS_16W;
        else if (remaining >= 32'd8) return AS_8W;
        else if (remaining >= 32'd4) return AS_4W;
        else                         return AS_1W;
    endfunction

endpackage

// File: rtl/mem_burst_reader_word_fifo.sv
// word_fifo: synchronous 32-bit FIFO with wrap-bit pointers.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write side; a push while full is taken only with a pop
//   pop, pop_data   read side; pop_data is the head word (show-ahead)
//   full, empty     status flags
//   count           words currently stored (0..DEPTH)
module word_fifo #(
    parameter int  DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push_ok;
    logic        w_pop_ok;

    // Top bit is the wrap bit: equal pointers mean empty, equal indexes
    // with differing wrap bits mean full.
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count    = r_wr_ptr - r_rd_ptr;
    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: read initiator for the main_memory port.
// Splits a (start address, word count) command into 16/8/4/1-word bursts,
// issues them on the memory request interface and buffers returned words.
// Ports:
//   clock, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_addr, cmd_words payload
//   address, access_size,
//   read_not_write, enable     memory request (accepted on enable && !busy)
//   busy, data_out             memory burst status and read beats
//   rd_data/rd_valid/rd_ready  output word stream
//   done                       one-cycle pulse when a command completes
//   dbg_state                  current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid never waits on ready, and payload is held stable
// while valid is high and ready is low.
module mem_burst_reader
    import mem_if_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 32,
    parameter int          CNT_W         = 8,
    parameter logic [31:0] START_ADDRESS = 32'h80020000
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [CNT_W-1:0] cmd_words,
    output logic [31:0]      address,
    output logic [1:0]       access_size,
    output logic             read_not_write,
    output logic             enable,
    input  logic             busy,
    input  logic [31:0]      data_out,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done,
    output state_t           dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_remaining;
    logic [1:0]       r_size;
    logic [4:0]       r_beat_cnt;
    logic             r_enable;
    logic             r_cmd_ready;
    logic             r_done;

    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_free;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_next_size;
    logic [4:0]       w_next_len;
    logic [4:0]       w_len;
    logic             w_credit_ok;

    assign w_push      = (r_state == ST_RECV);
    assign w_pop       = !w_empty && rd_ready;
    assign w_next_size = pick_size(32'(r_remaining));
    assign w_next_len  = burst_len(w_next_size);
    assign w_len       = burst_len(r_size);
    // Requests are only issued from ISSUE, where no beats are in flight,
    // so the free-slot count alone is the credit for the next burst.
    assign w_free      = CW'(FIFO_DEPTH) - w_count;
    assign w_credit_ok = !w_full && (w_free >= CW'(w_next_len));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= START_ADDRESS;
            r_remaining <= '0;
            r_size      <= AS_1W;
            r_beat_cnt  <= '0;
            r_enable    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr & ~32'h3;
                        r_remaining <= cmd_words;
                        r_state     <= (cmd_words == '0) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // enable is raised one cycle, then held until the
                    // memory takes it on an edge with busy low.
                    if (r_enable) begin
                        if (!busy) begin
                            r_enable   <= 1'b0;
                            r_beat_cnt <= w_len;
                            r_state    <= ST_RECV;
                        end
                    end else if (w_credit_ok && !busy) begin
                        r_enable <= 1'b1;
                        r_size   <= w_next_size;
                    end
                end
                ST_RECV: begin
                    r_beat_cnt <= r_beat_cnt - 5'd1;
                    if (r_beat_cnt == 5'd1) begin
                        r_addr      <= r_addr + {25'd0, w_len, 2'b00};
                        r_remaining <= r_remaining - CNT_W'(w_len);
                        r_state     <= (r_remaining == CNT_W'(w_len)) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst       (rst),
        .push      (w_push),
        .push_data (data_out),
        .pop       (w_pop),
        .pop_data  (rd_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign cmd_ready      = r_cmd_ready;
    assign address        = r_addr;
    assign access_size    = r_size;
    assign read_not_write = 1'b1;
    assign enable         = r_enable;
    assign rd_valid       = !w_empty;
    assign done           = r_done;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader with FIFO_DEPTH=16: directed command sequence,
// a main_memory model and scoreboard queues for bursts and output words.
module tb_mem_burst_reader;
    import mem_if_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          CNT_W = 8;
    localparam logic [31:0] START = 32'h80020000;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_addr = '0;
    logic [CNT_W-1:0] cmd_words = '0;
    logic [31:0]      address;
    logic [1:0]       access_size;
    logic             read_not_write;
    logic             enable;
    logic             busy = 1'b0;
    logic [31:0]      data_out = 32'hDEADBEEF;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             done;
    state_t           dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [1:0]  exp_size_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;

    mem_burst_reader #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .START_ADDRESS(START)
    ) dut (
        .clock(clock), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .address(address), .access_size(access_size),
        .read_not_write(read_not_write), .enable(enable),
        .busy(busy), .data_out(data_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic int blen(input logic [1:0] sz);
        case (sz)
            2'b11:   return 16;
            2'b10:   return 8;
            2'b01:   return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    // Expected words and greedy burst split for one command.
    task automatic push_expect(input logic [31:0] a, input int n);
        logic [31:0] p;
        int rem;
        int len;
        logic [1:0] sz;
        p = {a[31:2], 2'b00};
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(p + 32'(4 * i)));
        rem = n;
        while (rem > 0) begin
            if (rem >= 16)     begin len = 16; sz = 2'b11; end
            else if (rem >= 8) begin len = 8;  sz = 2'b10; end
            else if (rem >= 4) begin len = 4;  sz = 2'b01; end
            else               begin len = 1;  sz = 2'b00; end
            exp_addr_q.push_back(p);
            exp_size_q.push_back(sz);
            p = p + 32'(4 * len);
            rem -= len;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [31:0] a, input int n);
        int k;
        push_expect(a, n);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_words = CNT_W'(n);
        k = 0;
        forever begin
            @(negedge clock);
            if (cmd_ready || k > 100) break;
            k++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        cycles(4);
        check(tag, 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clock);
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        check({tag, "_bursts"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    // ---------------- main_memory model ----------------
    initial begin : mem_model
        logic [31:0] m_addr;
        logic [31:0] a_addr;
        int left;
        int a_len;
        logic acc;
        m_addr = '0;
        left = 0;
        forever begin
            @(negedge clock);
            acc    = !rst && enable && !busy;
            a_addr = address;
            a_len  = blen(access_size);
            if (acc) begin
                acc_cnt++;
                check("burst_pending", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("burst_addr", a_addr, exp_addr_q.pop_front());
                    check("burst_size", 32'(access_size), 32'(exp_size_q.pop_front()));
                end
                check("burst_rnw", 32'(read_not_write), 32'd1);
            end
            @(posedge clock); #1;
            if (acc) begin
                m_addr = a_addr;
                left   = a_len;
            end
            if (left > 0) begin
                data_out = mem_word(m_addr);
                m_addr   = m_addr + 32'd4;
                left--;
                busy     = (left > 0);
            end else begin
                busy     = 1'b0;
                data_out = 32'hDEADBEEF;
            end
        end
    end

    // ---------------- scoreboard: output stream and done ----------------
    initial begin : rd_monitor
        forever begin
            @(negedge clock);
            if (!rst && rd_valid && rd_ready) begin
                check("rd_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rd_data", rd_data, exp_q.pop_front());
            end
            if (!rst && done) done_cnt++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int a0;
        int k;
        int n;
        logic [31:0] a;

        // Reset values
        rst = 1'b1;
        cycles(2);
        @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_access_size", 32'(access_size), 32'd0);
        check("rst_rnw", 32'(read_not_write), 32'd1);
        check("rst_address", address, START);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clock); #1;
        rst = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 43 words, free-running consumer: bursts 16,16,8,1,1,1
        rd_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(32'h80020000, 43);
        wait_done(d0, 400, "t1_done");
        drain("t1_drain");
        check("t1_next_addr", address, 32'h800200AC);

        // 5 words, stalled consumer; low address bits ignored
        @(posedge clock); #1;
        rd_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(32'h80001003, 5);
        wait_done(d0, 200, "t2_done");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t2_rd_valid", 32'(rd_valid), 32'd1);
            check("t2_rd_frozen", rd_data, exp_q[0]);
        end
        @(posedge clock); #1;
        rd_ready = 1'b1;
        drain("t2_drain");

        // 40 words, stalled consumer: FIFO fills after first 16-word burst
        @(posedge clock); #1;
        rd_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(32'h80030000, 40);
        cycles(40);
        @(negedge clock);
        check("t3_enable_held", 32'(enable), 32'd0);
        check("t3_rd_valid", 32'(rd_valid), 32'd1);
        check("t3_bursts_left", 32'(exp_addr_q.size()), 32'd2);
        check("t3_state", 32'(dbg_state), 32'(ST_ISSUE));
        @(posedge clock); #1;
        rd_ready = 1'b1;
        wait_done(d0, 400, "t3_done");
        drain("t3_drain");

        // Zero-word command: no request, done two cycles after acceptance
        d0 = done_cnt;
        send_cmd(32'h80040000, 0);
        @(negedge clock);
        check("t4_done_c1", 32'(done), 32'd0);
        @(negedge clock);
        check("t4_done_c2", 32'(done), 32'd1);
        @(negedge clock);
        check("t4_done_c3", 32'(done), 32'd0);
        check("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        cycles(3);
        check("t4_done_once", 32'(done_cnt), 32'(d0 + 1));
        check("t4_address", address, 32'h80040000);

        // Reset after beat 7 of a 16-word burst
        a0 = acc_cnt;
        send_cmd(32'h80050000, 16);
        k = 0;
        while (acc_cnt == a0 && k < 50) begin
            @(posedge clock);
            k++;
        end
        check("t5_accepted", 32'(acc_cnt), 32'(a0 + 1));
        cycles(7);
        #2;
        rst = 1'b1;
        #1;
        check("t5_enable", 32'(enable), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_address", address, START);
        check("t5_access_size", 32'(access_size), 32'd0);
        check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        exp_addr_q.delete();
        exp_size_q.delete();
        cycles(2);
        #1;
        rst = 1'b0;
        d0 = done_cnt;
        send_cmd(32'h80060000, 4);
        wait_done(d0, 200, "t5_post_done");
        drain("t5_post_drain");

        // Address wrap
        d0 = done_cnt;
        send_cmd(32'hFFFFFFF8, 4);
        wait_done(d0, 200, "t6_done");
        drain("t6_drain");
        check("t6_wrap_addr", address, 32'h00000008);

        // Randomised length and start address
        n = int'($urandom_range(17, 60));
        a = 32'h90000000 + 32'($urandom_range(0, 255)) * 32'd4;
        d0 = done_cnt;
        send_cmd(a, n);
        wait_done(d0, 600, "t7_done");
        drain("t7_drain");
        check("t7_next_addr", address, a + 32'(4 * n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
